// File: rtl/prio_pkt_sched.sv
// prio_pkt_sched: strict-priority, packet-granular scheduler. It picks the
// highest-priority queue holding a complete packet, reads it beat by beat
// through a 2-entry output buffer, and never preempts a packet in progress.
//
// Output handshake: a beat moves downstream in every cycle where out_vld and
// out_rdy are both high. out_vld and the beat fields come straight from the
// buffer head register and never depend on out_rdy in the same cycle.
module prio_pkt_sched #(
    parameter  int DATA_WIDTH    = 256,
    parameter  int NUM_PRIO      = 8,
    parameter  int MAX_PKT_BEATS = 64,
    localparam int PW            = (NUM_PRIO > 1) ? $clog2(NUM_PRIO) : 1,
    localparam int CW            = $clog2(MAX_PKT_BEATS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PRIO-1:0]            q_pkt_rdy,
    output logic [NUM_PRIO-1:0]            q_read,
    input  logic [NUM_PRIO-1:0]            q_sop,
    input  logic [NUM_PRIO-1:0]            q_eop,
    input  logic [NUM_PRIO-1:0]            q_vld,
    input  logic [NUM_PRIO*DATA_WIDTH-1:0] q_data,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [PW-1:0]                  out_prio,
    output logic [NUM_PRIO-1:0]            grant,
    output logic                           busy,
    output logic                           err,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_g;
    logic [NUM_PRIO-1:0]   r_grant;
    logic [CW-1:0]         r_cnt;
    logic                  r_infl;
    logic                  r_err;

    // Two-entry output buffer, split into per-field arrays.
    logic                  r_b_sop  [2];
    logic                  r_b_eop  [2];
    logic [PW-1:0]         r_b_prio [2];
    logic [DATA_WIDTH-1:0] r_b_data [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_occ;

    logic [PW-1:0]         w_pick;
    logic                  w_ret_vld;
    logic                  w_ret_sop;
    logic                  w_ret_eop;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic                  w_accept;
    logic                  w_first;
    logic                  w_hit_max;
    logic                  w_end;
    logic                  w_err;
    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_credit;

    // Highest set request index wins (later loop iterations override).
    always_comb begin
        w_pick = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            if (q_pkt_rdy[i]) w_pick = PW'(i);
        end
    end

    assign w_ret_vld  = q_vld[r_g];
    assign w_ret_sop  = q_sop[r_g];
    assign w_ret_eop  = q_eop[r_g];
    assign w_ret_data = q_data[r_g*DATA_WIDTH +: DATA_WIDTH];

    // Only the granted queue's returns count, and only while transferring.
    assign w_accept  = (r_state == S_XFER) && w_ret_vld;
    assign w_first   = (r_cnt == '0);
    assign w_hit_max = w_accept && !w_ret_eop && (r_cnt == CW'(MAX_PKT_BEATS - 1));
    assign w_end     = w_accept && (w_ret_eop || w_hit_max);
    // First beat must carry sop and later beats must not; a forced eop is an error too.
    assign w_err     = w_accept && ((w_ret_sop != w_first) || w_hit_max);

    assign w_pop    = out_vld && out_rdy;
    // Count a beat leaving this cycle as freed space so a steady stream runs at full rate.
    assign w_level  = 3'(r_occ) + 3'(r_infl) - 3'(w_pop);
    assign w_credit = (w_level < 3'd2);

    // Next state and read strobe; reads stop in the very cycle the packet end returns.
    always_comb begin
        w_state_nxt = r_state;
        q_read      = '0;
        case (r_state)
            S_IDLE: begin
                if (|q_pkt_rdy) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_end) w_state_nxt = S_DRAIN;
                else if (w_credit) q_read[r_g] = 1'b1;
            end
            S_DRAIN: begin
                if (r_occ == 2'd0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus grant, beat count, in-flight flag and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_g     <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_infl  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_infl  <= |q_read;
            r_err   <= w_err;
            if ((r_state == S_IDLE) && (|q_pkt_rdy)) begin
                r_g     <= w_pick;
                r_grant <= {{(NUM_PRIO-1){1'b0}}, 1'b1} << w_pick;
                r_cnt   <= '0;
            end else begin
                if (w_accept && (r_cnt != CW'(MAX_PKT_BEATS))) r_cnt <= r_cnt + CW'(1);
                if (w_end) r_grant <= '0;
            end
        end
    end

    // Output buffer: push accepted beats with repaired sop/eop, pop on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_b_sop[i]  <= 1'b0;
                r_b_eop[i]  <= 1'b0;
                r_b_prio[i] <= '0;
                r_b_data[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_b_sop[r_wptr]  <= w_first;
                r_b_eop[r_wptr]  <= w_ret_eop || w_hit_max;
                r_b_prio[r_wptr] <= r_g;
                r_b_data[r_wptr] <= w_ret_data;
                r_wptr           <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_occ <= r_occ + 2'(w_accept) - 2'(w_pop);
        end
    end

    assign out_vld   = (r_occ != 2'd0);
    assign out_sop   = r_b_sop[r_rptr];
    assign out_eop   = r_b_eop[r_rptr];
    assign out_prio  = r_b_prio[r_rptr];
    assign out_data  = r_b_data[r_rptr];
    assign grant     = r_grant;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_prio_pkt_sched.sv
// Bench for prio_pkt_sched: per-queue beat memories answer reads one cycle
// later, expected output beats are queued in service order, and every
// accepted output beat is popped and compared.
module tb_prio_pkt_sched;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [7:0]      q_pkt_rdy;
  logic [7:0]      q_read;
  logic [7:0]      q_sop;
  logic [7:0]      q_eop;
  logic [7:0]      q_vld;
  logic [8*DW-1:0] q_data;
  logic            out_vld;
  logic            out_rdy;
  logic            out_sop;
  logic            out_eop;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_prio;
  logic [7:0]      grant;
  logic            busy;
  logic            err;
  logic [1:0]      dbg_state;

  prio_pkt_sched #(
    .DATA_WIDTH(DW),
    .NUM_PRIO(8),
    .MAX_PKT_BEATS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .q_pkt_rdy(q_pkt_rdy), .q_read(q_read),
    .q_sop(q_sop), .q_eop(q_eop), .q_vld(q_vld), .q_data(q_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .out_prio(out_prio),
    .grant(grant), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // beat memories: {sop, eop, data}
  logic [33:0] mem [8][$];
  // scoreboard: {prio, sop, eop, data}
  logic [36:0] exp_q[$];
  int rd_log[$];
  int pop_log[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int rd_total = 0;
  int pop_total = 0;
  int err_total = 0;
  int bad_rd = 0;
  int ohv = 0;
  int outstanding = 0;
  logic [7:0] pend;

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [36:0] mk(input logic [2:0] p, input logic s, input logic e,
                                     input logic [31:0] d);
    return {p, s, e, d};
  endfunction

  task automatic load_pkt(input int q, input int n);
    logic [31:0] d;
    for (int b = 0; b < n; b++) begin
      d = $urandom;
      mem[q].push_back({(b == 0), (b == n - 1), d});
      exp_q.push_back(mk(3'(q), (b == 0), (b == n - 1), d));
    end
  endtask

  task automatic wait_grant(input logic [7:0] g, input string tag, output bit saw_idle);
    saw_idle = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (!busy) saw_idle = 1'b1;
      if (grant == g) break;
    end
    check(tag, 64'(grant), 64'(g));
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !busy && !out_vld) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_pops(input int base, input int n, input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (pop_total - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // queue responder, noise on idle queues, and output monitor
  initial begin : bench_loop
    logic [33:0] b;
    logic [36:0] e;
    int j;
    pend = '0;
    forever begin
      @(negedge clk);
      q_vld = '0;
      q_sop = '0;
      q_eop = '0;
      q_data = '0;
      for (int i = 0; i < 8; i++) begin
        if (pend[i] === 1'b1) begin
          if (mem[i].size() > 0) begin
            b = mem[i].pop_front();
            q_vld[i] = 1'b1;
            q_sop[i] = b[33];
            q_eop[i] = b[32];
            q_data[i*DW +: DW] = b[31:0];
          end else begin
            bad_rd++;
          end
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        j = $urandom_range(0, 7);
        if (pend[j] !== 1'b1 && grant[j] !== 1'b1) begin
          q_vld[j] = 1'b1;
          q_sop[j] = 1'($urandom_range(0, 1));
          q_eop[j] = 1'($urandom_range(0, 1));
          q_data[j*DW +: DW] = $urandom;
        end
      end
      #1;
      cyc++;
      pend = q_read;
      if ($countones(q_read) > 1) ohv++;
      if (q_read != 8'd0 && !$isunknown(q_read)) begin
        rd_total++;
        rd_log.push_back(cyc);
      end
      if (err === 1'b1) err_total++;
      if (out_vld === 1'b1 && out_rdy === 1'b1) begin
        pop_total++;
        pop_log.push_back(cyc);
        check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat", 64'({out_prio, out_sop, out_eop, out_data}), 64'(e));
        end
      end
      outstanding = rd_total - pop_total;
    end
  end

  initial begin : main
    bit idle_seen;
    int rd_b;
    int err_b;
    int pop_b;
    int mx;
    logic [31:0] d;

    rst = 1'b1;
    q_pkt_rdy = '0;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_q_read", 64'(q_read), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_fields", 64'({out_sop, out_eop, out_prio}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single packet on queue 2
    rd_b = rd_total;
    err_b = err_total;
    load_pkt(2, 3);
    @(negedge clk);
    q_pkt_rdy = 8'h04;
    wait_grant(8'h04, "t1_grant", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h00;
    wait_done("t1_done");
    check("t1_reads", 64'(rd_total - rd_b), 64'd3);
    check("t1_read_consec", 64'(rd_log[$] - rd_log[$-2]), 64'd2);
    check("t1_pop_consec", 64'(pop_log[$] - pop_log[$-2]), 64'd2);
    check("t1_err", 64'(err_total - err_b), 64'd0);

    // priority: 7 before 0, idle between packets
    load_pkt(7, 3);
    load_pkt(0, 2);
    @(negedge clk);
    q_pkt_rdy = 8'h81;
    wait_grant(8'h80, "prio_grant7", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h01;
    wait_grant(8'h01, "prio_grant0", idle_seen);
    check("prio_idle_between", 64'(idle_seen), 64'd1);
    @(negedge clk);
    q_pkt_rdy = 8'h00;
    wait_done("prio_done");

    // non-preemption: queue 6 arrives while queue 1 is mid-packet
    load_pkt(1, 4);
    load_pkt(6, 2);
    @(negedge clk);
    q_pkt_rdy = 8'h02;
    wait_grant(8'h02, "np_grant1", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h40;
    @(negedge clk);
    #2;
    check("np_no_preempt", 64'(grant), 64'h02);
    wait_grant(8'h40, "np_grant6", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h00;
    wait_done("np_done");

    // backpressure: 5 stalled cycles after the first beat leaves
    rd_b = rd_total;
    pop_b = pop_total;
    load_pkt(4, 4);
    @(negedge clk);
    q_pkt_rdy = 8'h10;
    wait_grant(8'h10, "bp_grant", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h00;
    wait_pops(pop_b, 1, "bp_first_pop");
    mx = 0;
    begin
      int rd_s;
      rd_s = rd_total;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        out_rdy = 1'b0;
        #2;
        if (outstanding > mx) mx = outstanding;
      end
      check("bp_no_read_in_stall", 64'(rd_total - rd_s), 64'd0);
    end
    check("bp_max_buffered", 64'(mx <= 2), 64'd1);
    check("bp_buffer_held", 64'(out_vld), 64'd1);
    @(negedge clk);
    out_rdy = 1'b1;
    wait_done("bp_done");
    check("bp_reads", 64'(rd_total - rd_b), 64'd4);

    // missing eop: forced termination after 4 beats
    rd_b = rd_total;
    err_b = err_total;
    for (int b = 0; b < 6; b++) begin
      d = $urandom;
      mem[3].push_back({(b == 0), 1'b0, d});
      if (b < 4) exp_q.push_back(mk(3'd3, (b == 0), (b == 3), d));
    end
    @(negedge clk);
    q_pkt_rdy = 8'h08;
    wait_grant(8'h08, "meop_grant", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h00;
    wait_done("meop_done");
    check("meop_reads", 64'(rd_total - rd_b), 64'd4);
    check("meop_err", 64'(err_total - err_b), 64'd1);
    mem[3].delete();

    // sop errors: first beat lacks sop, second carries a stray sop
    err_b = err_total;
    for (int b = 0; b < 3; b++) begin
      d = $urandom;
      mem[5].push_back({(b == 1), (b == 2), d});
      exp_q.push_back(mk(3'd5, (b == 0), (b == 2), d));
    end
    @(negedge clk);
    q_pkt_rdy = 8'h20;
    wait_grant(8'h20, "sop_grant", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h00;
    wait_done("sop_done");
    check("sop_err", 64'(err_total - err_b), 64'd2);

    // reset in the middle of a packet
    pop_b = pop_total;
    load_pkt(6, 4);
    @(negedge clk);
    q_pkt_rdy = 8'h40;
    wait_grant(8'h40, "mrst_grant", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h00;
    wait_pops(pop_b, 2, "mrst_two_beats");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("mrst_out_vld", 64'(out_vld), 64'd0);
    check("mrst_grant", 64'(grant), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_q_read", 64'(q_read), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mem[6].delete();
    repeat (2) @(negedge clk);
    rd_b = rd_total;
    load_pkt(2, 3);
    q_pkt_rdy = 8'h04;
    wait_grant(8'h04, "mrst_fresh_grant", idle_seen);
    @(negedge clk);
    q_pkt_rdy = 8'h00;
    wait_done("mrst_fresh_done");
    check("mrst_fresh_reads", 64'(rd_total - rd_b), 64'd3);

    // global
    check("no_bad_reads", 64'(bad_rd), 64'd0);
    check("read_onehot", 64'(ohv), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
